// File: rtl/taillight_sequencer.sv
// Three-lamp sequential turn signal with hazard and brake overlay.
// Ports:
//   clk, reset (async, active-high)
//   left, right, hazard, brake: level requests, already synchronous to clk
//   la/lb/lc, ra/rb/rc: left/right lamps, inner to outer
//   busy: high when not IDLE
//   tick: one-cycle pulse on the last cycle of each step
module taillight_sequencer #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    input  logic hazard,
    input  logic brake,
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic busy,
    output logic tick
);

    typedef enum logic [1:0] {
        IDLE,
        LSEQ,
        RSEQ,
        HAZ
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TICK_DIV - 1);

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [1:0] step, step_nx;
    logic       phase, phase_nx;

    logic       both;
    logic       own_req;
    logic       other_req;
    state_t     other_seq;
    logic [2:0] pat;
    logic [2:0] lamp_l, lamp_r;

    assign both = left & right;
    assign busy = (state != IDLE);
    assign tick = busy && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            step  <= 2'd0;
            phase <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            step  <= step_nx;
            phase <= phase_nx;
        end
    end

    always_comb begin
        own_req   = (state == LSEQ) ? left  : right;
        other_req = (state == LSEQ) ? right : left;
        other_seq = (state == LSEQ) ? RSEQ  : LSEQ;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = tick ? 8'd0 : cnt + 8'd1;
        step_nx  = step;
        phase_nx = phase;
        unique case (state)
            IDLE: begin
                cnt_nx   = 8'd0;
                step_nx  = 2'd0;
                phase_nx = 1'b0;
                if (hazard || both) state_nx = HAZ;
                else if (left)      state_nx = LSEQ;
                else if (right)     state_nx = RSEQ;
            end
            LSEQ, RSEQ: begin
                if (hazard) begin
                    // Hazard cuts the sequence short, starting a fresh flash.
                    state_nx = HAZ;
                    cnt_nx   = 8'd0;
                    step_nx  = 2'd0;
                    phase_nx = 1'b0;
                end else if (tick) begin
                    step_nx = step + 2'd1;
                    // Opposite-side requests are only honoured here, at
                    // the end of step3, so a sequence always completes.
                    if (step == 2'd3) begin
                        if (own_req)        state_nx = state;
                        else if (both)      state_nx = HAZ;
                        else if (other_req) state_nx = other_seq;
                        else                state_nx = IDLE;
                    end
                end
            end
            HAZ: begin
                if (tick) begin
                    phase_nx = ~phase;
                    // Both levers held together count as a hazard request.
                    if (!(hazard || both)) begin
                        state_nx = IDLE;
                        step_nx  = 2'd0;
                        phase_nx = 1'b0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pat = 3'b000;
        unique case (step)
            2'd0: pat = 3'b100;
            2'd1: pat = 3'b110;
            2'd2: pat = 3'b111;
            2'd3: pat = 3'b000;
            default: pat = 3'b000;
        endcase
    end

    always_comb begin
        lamp_l = {3{brake}};
        lamp_r = {3{brake}};
        unique case (state)
            LSEQ: lamp_l = pat;
            RSEQ: lamp_r = pat;
            HAZ: begin
                lamp_l = {3{~phase}};
                lamp_r = {3{~phase}};
            end
            default: ;
        endcase
    end

    assign {la, lb, lc} = lamp_l;
    assign {ra, rb, rc} = lamp_r;

endmodule

// File: tb/tb_taillight_sequencer.sv
// Directed self-checking bench for taillight_sequencer, TICK_DIV = 4.
// Inputs change 2 time units after a rising edge; outputs sampled mid-cycle.
module tb_taillight_sequencer;

    logic clk = 1'b0;
    logic reset, left, right, hazard, brake;
    logic la, lb, lc, ra, rb, rc, busy, tick;

    int n_chk  = 0;
    int n_pass = 0;

    logic [2:0] pat_t [4];

    taillight_sequencer #(.TICK_DIV(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .left   (left),
        .right  (right),
        .hazard (hazard),
        .brake  (brake),
        .la     (la),
        .lb     (lb),
        .lc     (lc),
        .ra     (ra),
        .rb     (rb),
        .rc     (rc),
        .busy   (busy),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        pat_t[0] = 3'b100;
        pat_t[1] = 3'b110;
        pat_t[2] = 3'b111;
        pat_t[3] = 3'b000;

        reset = 1'b1; left = 1'b0; right = 1'b0;
        hazard = 1'b0; brake = 1'b0;

        // reset state
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        chk("rst_l", {la, lb, lc}, 3'b000);
        chk("rst_r", {ra, rb, rc}, 3'b000);
        brake = 1'b1; #1;
        chk("rst_brk_l", {la, lb, lc}, 3'b111);
        chk("rst_brk_r", {ra, rb, rc}, 3'b111);
        brake = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);

        // left held 20 cycles, then released; sequence runs out to IDLE
        left = 1'b1; #1;
        chk("l20_busy0", busy, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("l20_busy", busy, 1);
            chk("l20_l", {la, lb, lc}, pat_t[(i / 4) % 4]);
            chk("l20_r", {ra, rb, rc}, 3'b000);
            chk("l20_tick", tick, (i % 4 == 3) ? 1 : 0);
        end
        left = 1'b0;
        cyc(12);
        chk("l20_last_tick", tick, 1);
        cyc(1);
        chk("l20_idle", busy, 0);

        // left pulse, right during step1: LSEQ completes, then RSEQ
        left = 1'b1;
        cyc(1);
        left = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (j == 5) begin
                right = 1'b1; #1;
            end
            chk("arb_busy", busy, 1);
            chk("arb_l", {la, lb, lc}, pat_t[j / 4]);
            chk("arb_r", {ra, rb, rc}, 3'b000);
            cyc(1);
        end
        chk("arb_rseq_r", {ra, rb, rc}, 3'b100);
        chk("arb_rseq_l", {la, lb, lc}, 3'b000);
        right = 1'b0;
        cyc(16);
        chk("arb_idle", busy, 0);

        // left and right together: hazard flash
        left = 1'b1; right = 1'b1;
        cyc(1);
        for (int k = 0; k < 12; k++) begin
            chk("both_l", {la, lb, lc}, ((k / 4) % 2 == 0) ? 3'b111 : 3'b000);
            chk("both_r", {ra, rb, rc}, ((k / 4) % 2 == 0) ? 3'b111 : 3'b000);
            chk("both_tick", tick, (k % 4 == 3) ? 1 : 0);
            if (k == 9) begin
                left = 1'b0; right = 1'b0;
            end
            cyc(1);
        end
        chk("both_idle", busy, 0);
        chk("both_idle_l", {la, lb, lc}, 3'b000);

        // RSEQ step2 with brake, then hazard preempts mid-step
        right = 1'b1;
        cyc(1);
        chk("rs_step0", {ra, rb, rc}, 3'b100);
        cyc(8);
        brake = 1'b1; #1;
        chk("rs_brk_l", {la, lb, lc}, 3'b111);
        chk("rs_brk_r", {ra, rb, rc}, 3'b111);
        cyc(1);
        hazard = 1'b1; #1;
        chk("rs_pre_r", {ra, rb, rc}, 3'b111);
        cyc(1);
        chk("hz_busy", busy, 1);
        chk("hz_l", {la, lb, lc}, 3'b111);
        chk("hz_r", {ra, rb, rc}, 3'b111);
        chk("hz_tick0", tick, 0);
        cyc(4);
        chk("hz_ph1_l", {la, lb, lc}, 3'b000);
        chk("hz_ph1_r", {ra, rb, rc}, 3'b000);
        hazard = 1'b0; right = 1'b0; brake = 1'b0;
        cyc(3);
        chk("hz_tick", tick, 1);
        cyc(1);
        chk("hz_idle", busy, 0);

        // async reset in LSEQ step1
        left = 1'b1;
        cyc(1);
        cyc(5);
        chk("ar_step1", {la, lb, lc}, 3'b110);
        #1 reset = 1'b1; #1;
        chk("ar_l", {la, lb, lc}, 3'b000);
        chk("ar_r", {ra, rb, rc}, 3'b000);
        chk("ar_busy", busy, 0);
        chk("ar_tick", tick, 0);
        cyc(1);
        reset = 1'b0; #1;
        chk("ar_rel_busy", busy, 0);
        cyc(1);
        chk("ar_restart_busy", busy, 1);
        chk("ar_restart_l", {la, lb, lc}, 3'b100);
        left = 1'b0;
        cyc(16);
        chk("ar_idle", busy, 0);

        // brake toggling while idle
        for (int b = 0; b < 6; b++) begin
            brake = (b % 2 == 0); #1;
            chk("ib_l", {la, lb, lc}, brake ? 3'b111 : 3'b000);
            chk("ib_r", {ra, rb, rc}, brake ? 3'b111 : 3'b000);
            chk("ib_busy", busy, 0);
            chk("ib_tick", tick, 0);
            cyc(1);
        end
        brake = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
